multdiv_controller: RTL and testbench
=====================================

Name: multdiv_controller

Overview:
- Iterative multiply/divide sequencer beside the execute stage.
- On a multiply or divide start from the execute stage, it latches both operands and the destination register, then runs a 32-step shift-add multiply or restoring divide.
- It stalls the pipeline while running, then returns one result with its rd tag.
- Frees the single-cycle ALU path from 32-bit multiply/divide.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- start_mult  input  1  one-cycle request for signed multiply of num_a*num_b.
- start_div  input  1  one-cycle request for signed divide num_a/num_b.
- num_a  input  WIDTH  operand A (multiplicand or dividend).
- num_b  input  WIDTH  operand B (multiplier or divisor).
- rd_in  input  5  destination register tag for the request.
- stall  output  1  holds the upstream pipeline (PC, decode, execute) frozen.
- busy  output  1  operation in progress (state MULT or DIV).
- result_valid  output  1  one-cycle pulse; result and out_rd are valid.
- result  output  WIDTH  low WIDTH bits of the product, or the quotient.
- out_rd  output  5  rd tag latched at start.
- exception  output  1  qualified by result_valid: divide-by-zero, or multiply overflow.

Behaviour:
- States: IDLE, MULT, DIV, DONE.
- Reset (reset==0 at an edge) from any state, mid-operation included:
  - state goes to IDLE and the in-flight operation is discarded.
  - Outputs: stall=0, busy=0, result_valid=0, result=0, out_rd=0, exception=0.
  - Counter and internal registers are cleared.
- IDLE:
  - start_mult=1 latches |num_a|, |num_b|, sign flags and rd_in, clears counter and goes to MULT.
  - start_div=1 does the same and goes to DIV.
  - start_mult and start_div together: multiply wins and divide is dropped.
  - start_div with num_b==0 goes directly to DONE with result=0, exception=1. No iterations run.
- MULT:
  - One shift-add step per cycle over 64-bit unsigned accumulator {hi,lo}. Counter increments.
  - When counter==WIDTH-1, go to DONE.
  - Sign fix-up when entering DONE: negate if sign_a^sign_b.
  - exception=1 if the signed 64-bit product does not fit in signed WIDTH bits.
  - result = low WIDTH bits of the product.
- DIV:
  - One restoring step per cycle on the unsigned magnitudes. After WIDTH steps, go to DONE.
  - Quotient truncates toward zero and is negated if signs differ. The remainder is discarded.
  - 0x80000000 / 0xFFFFFFFF gives result=0x80000000, exception=1.
- DONE:
  - result_valid=1 for exactly one cycle, then IDLE.
  - result, out_rd and exception hold their values until the next DONE or reset.
- stall (combinational):
  - 1 when state is MULT or DIV, or when state is IDLE and either start is high.
  - 0 in DONE, so the pipeline advances on the same edge that result_valid is sampled.
- Latency: with a start sampled at edge E, result_valid is high in the cycle after edge E+WIDTH+1 (33 cycles at WIDTH=32). Divide-by-zero takes 1 cycle.
- Starts seen in MULT, DIV or DONE are ignored. The requester is stalled, so none are legal then.
- Counter width: CNT_W bits; the terminal compare is at WIDTH-1, with no wrap beyond it.

Optional Feature:
- Macro MULTDIV_EARLY_OUT_EN.
- When defined: in MULT, if the remaining unshifted multiplier bits are all zero, go to DONE on the next edge. Example: 7*3 finishes in 3 cycles (2 iterations + DONE). The result is identical.
- When undefined: multiply always takes the full WIDTH iterations. Divide latency is unaffected in both cases.

Test Plan:
- Reset low for 2 cycles mid-MULT, then high -> state IDLE, all outputs 0, no result_valid pulse follows.
- start_mult, num_a=0xFFFFFFFA (-6), num_b=7, rd_in=5 -> stall high 33 cycles, then result_valid=1, result=0xFFFFFFD6 (-42), out_rd=5, exception=0.
- start_div, num_a=100, num_b=0xFFFFFFF9 (-7), rd_in=9 -> after 33 cycles result=0xFFFFFFF2 (-14), out_rd=9, exception=0.
- start_div, num_b=0, rd_in=3 -> result_valid on the next cycle, result=0, exception=1, stall high for 1 cycle only.
- start_mult, num_a=0x00010000, num_b=0x00010000 -> result=0x00000000, exception=1 (overflow).
- start_mult and start_div together with 3 and 4 -> multiply wins, result=12. A start_div pulsed mid-operation is ignored: exactly one result_valid is produced.

Source files
------------

// File: rtl/multdiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
// The master drives requests and operands. The slave returns the stall, the result and the rd tag.
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] num_a;
  logic [WIDTH-1:0] num_b;
  logic [4:0]       rd_in;
  logic             stall;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       out_rd;
  logic             exception;

  modport master (
    output start_mult, start_div, num_a, num_b, rd_in,
    input  stall, busy, result_valid, result, out_rd, exception
  );

  modport slave (
    input  start_mult, start_div, num_a, num_b, rd_in,
    output stall, busy, result_valid, result, out_rd, exception
  );
endinterface

// File: rtl/multdiv_controller.sv
// Iterative signed multiply (shift-add) / divide (restoring) sequencer; result valid WIDTH+1 edges after start.
// Stalls the pipeline while running; optional multiply early-out under `MULTDIV_EARLY_OUT_EN.
module multdiv_controller #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic      clock_i,
  input  logic      reset_ni,
  multdiv_if.slave  md
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fin_q, fin_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [4:0]         tag_q, tag_d, out_rd_q, out_rd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;

  logic [WIDTH-1:0]   abs_a, abs_b, quo_s;
  logic [2*WIDTH-1:0] acc_step, prod_src, prod_s;
  logic [WIDTH:0]     trial;
  logic               neg, early, mult_ovf, div_ovf, busy;

  assign abs_a    = md.num_a[WIDTH-1] ? -md.num_a : md.num_a;
  assign abs_b    = md.num_b[WIDTH-1] ? -md.num_b : md.num_b;
  assign neg      = sign_a_q ^ sign_b_q;
  assign acc_step = b_q[0] ? acc_q + mcand_q : acc_q;
`ifdef MULTDIV_EARLY_OUT_EN
  assign early    = (b_q[WIDTH-1:1] == '0);
`else
  assign early    = 1'b0;
`endif
  // The final fix-up reads the accumulator as it stands after the last step taken.
  assign prod_src = fin_q ? acc_q : acc_step;
  assign prod_s   = neg ? -prod_src : prod_src;
  assign mult_ovf = (prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_s[WIDTH-1]}});
  assign trial    = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
  assign quo_s    = neg ? -a_q : a_q;
  assign div_ovf  = !neg && a_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    tag_d    = tag_q;
    out_rd_d = out_rd_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      S_IDLE: begin
        if (md.start_mult || md.start_div) begin
          sign_a_d = md.num_a[WIDTH-1];
          sign_b_d = md.num_b[WIDTH-1];
          a_d      = abs_a;
          b_d      = abs_b;
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          acc_d    = '0;
          rem_d    = '0;
          cnt_d    = '0;
          fin_d    = 1'b0;
          tag_d    = md.rd_in;
          if (md.start_mult) begin
            state_d = S_MULT;
          end else if (md.num_b == '0) begin
            state_d  = S_DONE;
            result_d = '0;
            exc_d    = 1'b1;
            out_rd_d = md.rd_in;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MULT: begin
        if (!fin_q) begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
          if (cnt_q == CNT_LAST) fin_d = 1'b1;
          else                   cnt_d = cnt_q + CNT_W'(1);
        end
        if (fin_q || early) begin
          state_d  = S_DONE;
          result_d = prod_s[WIDTH-1:0];
          exc_d    = mult_ovf;
          out_rd_d = tag_q;
        end
      end
      S_DIV: begin
        if (fin_q) begin
          state_d  = S_DONE;
          result_d = quo_s;
          exc_d    = div_ovf;
          out_rd_d = tag_q;
        end else begin
          // The dividend shifts out of a_q while quotient bits shift in.
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CNT_LAST) fin_d = 1'b1;
          else                   cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      tag_q    <= '0;
      out_rd_q <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      tag_q    <= tag_d;
      out_rd_q <= out_rd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign busy            = (state_q == S_MULT) || (state_q == S_DIV);
  assign md.busy         = busy;
  assign md.stall        = busy || ((state_q == S_IDLE) && (md.start_mult || md.start_div));
  assign md.result_valid = (state_q == S_DONE);
  assign md.result       = result_q;
  assign md.out_rd       = out_rd_q;
  assign md.exception    = exc_q;
endmodule

// File: tb/tb_multdiv_controller.sv
// Self-checking bench for multdiv_controller: directed vector table, hand-written corner sequences,
// and random operations compared against an arithmetic reference model.
module tb_multdiv_controller;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multdiv_if #(.WIDTH(W)) md();
  multdiv_controller #(.WIDTH(W), .CNT_W(5)) dut (.clock_i(clk), .reset_ni(rst_n), .md(md));

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          mul;
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edges after the start edge until result_valid is seen.
  function automatic int exp_lat(input bit is_mul, input logic [31:0] b);
    int lat;
    logic [31:0] mag;
    mag = b[31] ? -b : b;
    lat = W + 1;
    if (!is_mul && b == 32'd0) lat = 0;
`ifdef MULTDIV_EARLY_OUT_EN
    if (is_mul) begin
      lat = 1;
      for (int i = 1; i < 32; i++) if ((mag >> i) != 32'd0) lat = i + 1;
    end
`endif
    return lat;
  endfunction

  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  task automatic run_op(input string tag, input bit mul, input bit div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] er, input logic ee, input int elat);
    int n;
    bit stall_ok;
    @(negedge clk);
    md.start_mult = mul;
    md.start_div  = div;
    md.num_a      = a;
    md.num_b      = b;
    md.rd_in      = rd;
    #1 stall_ok = (md.stall === 1'b1);
    @(posedge clk);
    #1;
    md.start_mult = 1'b0;
    md.start_div  = 1'b0;
    n = 0;
    while (md.result_valid !== 1'b1 && n < 200) begin
      if (md.stall !== 1'b1 || md.busy !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(elat));
    check({tag, ".result"}, {32'd0, md.result}, {32'd0, er});
    check({tag, ".out_rd"}, {59'd0, md.out_rd}, {59'd0, rd});
    check({tag, ".exception"}, {63'd0, md.exception}, {63'd0, ee});
    check({tag, ".stall"}, {62'd0, stall_ok, md.stall}, {62'd0, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    check({tag, ".pulse_hold"}, {29'd0, md.result_valid, md.busy, md.result},
          {29'd0, 1'b0, 1'b0, er});
  endtask

  task automatic outs_zero(input string tag);
    check(tag, {23'd0, md.stall, md.busy, md.result_valid, md.result, md.out_rd, md.exception}, 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int pulses;
    logic [31:0] ra, rb, rr;
    logic re;
    bit rm;

    tbl[0] = '{1'b1, 1'b0, 32'hFFFF_FFFA, 32'd7,          5'd5,  32'hFFFF_FFD6, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'd100,       32'hFFFF_FFF9,  5'd9,  32'hFFFF_FFF2, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'd1234,      32'd0,          5'd3,  32'd0,         1'b1};
    tbl[3] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000,  5'd7,  32'd0,         1'b1};
    tbl[4] = '{1'b1, 1'b1, 32'd3,         32'd4,          5'd11, 32'd12,        1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  5'd1,  32'h8000_0000, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'd7,         32'd3,          5'd2,  32'd21,        1'b0};
    tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FF9B, 32'd10,         5'd30, 32'hFFFF_FFF6, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 32'h8000_0000, 32'd1,          5'd31, 32'h8000_0000, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  5'd4,  32'h8000_0000, 1'b1};

    md.start_mult = 1'b0;
    md.start_div  = 1'b0;
    md.num_a      = '0;
    md.num_b      = '0;
    md.rd_in      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    outs_zero("reset_state");

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].mul, tbl[i].div, tbl[i].a, tbl[i].b, tbl[i].rd,
             tbl[i].er, tbl[i].ee, exp_lat(tbl[i].mul, tbl[i].b));
    end

    // A start_div pulsed mid-multiply must not produce a second result.
    @(negedge clk);
    md.start_mult = 1'b1;
    md.num_a = 32'd5;
    md.num_b = 32'd6;
    md.rd_in = 5'd8;
    @(posedge clk);
    #1 md.start_mult = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 1) begin
        md.start_div = 1'b1;
        md.num_b = 32'd0;
      end else begin
        md.start_div = 1'b0;
      end
      if (md.result_valid === 1'b1) begin
        pulses++;
        check("midop.result", {32'd0, md.result}, 64'd30);
      end
      @(posedge clk);
      #1;
    end
    check("midop.pulses", 64'(pulses), 64'd1);

    // Reset held low for two edges in the middle of a multiply.
    @(negedge clk);
    md.start_mult = 1'b1;
    md.num_a = 32'hFFFF_FFFA;
    md.num_b = 32'd7;
    md.rd_in = 5'd5;
    @(posedge clk);
    #1 md.start_mult = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs_zero("midreset.during");
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (md.result_valid === 1'b1 || md.busy === 1'b1) pulses++;
    end
    check("midreset.no_result", 64'(pulses), 64'd0);
    outs_zero("midreset.after");

    for (int i = 0; i < 40; i++) begin
      rm = $urandom_range(0, 1) == 1;
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(0, 20) - 10;
        2: rb = $urandom_range(0, 65535);
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 2) == 0) ra = $urandom_range(0, 2000) - 1000;
      model(rm, ra, rb, rr, re);
      run_op($sformatf("rand%0d", i), rm, !rm, ra, rb, 5'($urandom_range(0, 31)), rr, re,
             exp_lat(rm, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
